fifo_addr_ctrl: RTL and testbench
=================================

FIFO_ADDR_CTRL -- requirements
Module: fifo_addr_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 3, address width; depth = 2**ADDR_W.
REQ-002 SHALL have parameter AF_TH, default 2**ADDR_W-1, almost-full threshold (entries).
REQ-003 SHALL have parameter AE_TH, default 1, almost-empty threshold (entries).
REQ-004 SHALL have port clk  in  1  single clock; all state updates on posedge.
REQ-005 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port rw  in  1  0 = read request, 1 = write request.
REQ-007 SHALL have port key  in  1  operation request, level input, edge-detected internally.
REQ-008 SHALL have port flush  in  1  synchronous clear of pointers and error flags.
REQ-009 SHALL have port out_addr  out  ADDR_W  memory address: write_ptr low bits if rw=1, else read_ptr low bits.
REQ-010 SHALL have port we  out  1  one-cycle memory write strobe.
REQ-011 SHALL have port re  out  1  one-cycle memory read strobe.
REQ-012 SHALL have ports full, empty, almost_full, almost_empty  out  1 each  status flags.
REQ-013 SHALL have port count  out  ADDR_W+1  occupancy, 0..2**ADDR_W.
REQ-014 SHALL have ports overflow, underflow  out  1 each  sticky error flags.

Function
REQ-015 SHALL hold read_ptr, write_ptr as ADDR_W+1-bit wrap counters (MSB = lap bit), incremented modulo 2**(ADDR_W+1).
REQ-016 SHALL compute count = write_ptr - read_ptr, modulo 2**(ADDR_W+1).
REQ-017 SHALL drive flags combinationally from registered pointers: empty = (count==0); full = (count==2**ADDR_W); almost_full = (count>=AF_TH); almost_empty = (count<=AE_TH).
REQ-018 SHALL accept one operation per key rising edge; a held key triggers nothing further until released.
REQ-019 SHALL implement states IDLE, READ_CHECK, WRITE_CHECK, READ, WRITE.
REQ-020 IDLE: key edge with rw=0 -> READ_CHECK; with rw=1 -> WRITE_CHECK; else stay.
REQ-021 READ_CHECK: empty -> set underflow, -> IDLE; else -> READ.
REQ-022 WRITE_CHECK: full -> set overflow, -> IDLE; else -> WRITE.
REQ-023 READ: assert re for exactly this cycle, out_addr = read_ptr[ADDR_W-1:0], read_ptr+1 at cycle end, -> IDLE.
REQ-024 WRITE: assert we for exactly this cycle, out_addr = write_ptr[ADDR_W-1:0], write_ptr+1 at cycle end, -> IDLE.
REQ-025 SHALL latch rw at key edge; rw changes after the edge do not alter the operation in flight, and out_addr follows latched rw during CHECK/READ/WRITE states.
REQ-026 Latency: edge sampled cycle N -> CHECK in N+1 -> strobe in N+2 -> flags/count updated N+3.
REQ-027 flush: pointers to 0, overflow/underflow cleared, state -> IDLE, we/re suppressed that cycle; flush takes priority over any key edge and any state.
REQ-028 Wrap: pointer low bits wrap 2**ADDR_W-1 -> 0; lap bit toggles; full/empty remain correct across any number of laps.
REQ-029 we and re SHALL never be asserted in the same cycle.

Reset
REQ-030 rst_n low SHALL immediately force: state IDLE, pointers 0, count 0, empty=1, almost_empty=1, full=0, almost_full=0 (for AF_TH>0), we=re=0, overflow=underflow=0, edge detector cleared.
REQ-031 Reset asserted mid-operation (any state) SHALL abort without a strobe; no key edge is recognised in the first cycle after release unless key was low then rose.

Structure
REQ-032 State enum typedef and default threshold constants SHALL live in shared package fifo_ctrl_pkg.
REQ-033 Key edge detection (registered key, rising-edge pulse) SHALL be sub-module key_edge.

Verification
REQ-034 After reset, read key press (ADDR_W=3) -> no re, underflow=1, empty=1, count=0.
REQ-035 Eight write presses -> we pulses at out_addr 0..7, count=8, full=1; ninth press -> no we, overflow=1.
REQ-036 Write 8, read 8, write 3 -> write addresses 0,1,2 on lap 2, count=3, empty=0, full=0.
REQ-037 Key held high 20 cycles with rw=1 -> exactly one we pulse, count=1.
REQ-038 flush asserted during WRITE_CHECK with count=5 -> no we, count=0, empty=1, overflow cleared, state IDLE.
REQ-039 rst_n low during READ state -> re deasserted immediately, pointers 0, empty=1.

Source files
------------

// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the FIFO address controller: FSM state encoding
// and default parameter values.
package fifo_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ_CHECK,
        WRITE_CHECK,
        READ,
        WRITE
    } state_e;

    localparam int DEF_ADDR_W = 3;
    localparam int DEF_AE_TH  = 1;

    // Almost-full defaults to one entry short of the full depth.
    function automatic int def_af_th(input int addr_w);
        return (1 << addr_w) - 1;
    endfunction

endpackage

// File: rtl/key_edge.sv
// Rising-edge detector for the operation key: one-cycle pulse per press.
module key_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic key_i,
    output logic rise_o
);

    logic key_q;

    // Reset value 1 means a key held through reset is not an edge; it must
    // be released and pressed again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q <= 1'b1;
        end else begin
            key_q <= key_i;
        end
    end

    assign rise_o = key_i & ~key_q;

endmodule

// File: rtl/fifo_addr_ctrl.sv
// FIFO address/strobe controller: one read or write per key press, with
// wrap-counter pointers, occupancy flags and sticky over/underflow errors.
module fifo_addr_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int AF_TH  = def_af_th(ADDR_W),
    parameter int AE_TH  = DEF_AE_TH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rw,
    input  logic              key,
    input  logic              flush,
    output logic [ADDR_W-1:0] out_addr,
    output logic              we,
    output logic              re,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W:0] PTR_ZERO = '0;
    localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] DEPTH    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] AF_TH_C  = AF_TH[ADDR_W:0];
    localparam logic [ADDR_W:0] AE_TH_C  = AE_TH[ADDR_W:0];

    state_e          state_q, state_d;
    logic            rw_q, rw_d;
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic            key_rise;
    logic            sel_wr;

    key_edge u_key_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .key_i  (key),
        .rise_o (key_rise)
    );

    // Extra lap bit makes the subtraction distinguish full from empty.
    assign count        = wr_ptr_q - rd_ptr_q;
    assign empty        = (count == PTR_ZERO);
    assign full         = (count == DEPTH);
    assign almost_full  = (count >= AF_TH_C);
    assign almost_empty = (count <= AE_TH_C);
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

    // Live rw only while idle; once an operation is in flight, the latched copy.
    assign sel_wr   = (state_q == IDLE) ? rw : rw_q;
    assign out_addr = sel_wr ? wr_ptr_q[ADDR_W-1:0] : rd_ptr_q[ADDR_W-1:0];

    always_comb begin
        state_d  = state_q;
        rw_d     = rw_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        we       = 1'b0;
        re       = 1'b0;
        if (flush) begin
            state_d  = IDLE;
            rd_ptr_d = PTR_ZERO;
            wr_ptr_d = PTR_ZERO;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (key_rise) begin
                        rw_d    = rw;
                        state_d = rw ? WRITE_CHECK : READ_CHECK;
                    end
                end
                READ_CHECK: begin
                    if (empty) begin
                        unf_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = READ;
                    end
                end
                WRITE_CHECK: begin
                    if (full) begin
                        ovf_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = WRITE;
                    end
                end
                READ: begin
                    re       = 1'b1;
                    rd_ptr_d = rd_ptr_q + PTR_ONE;
                    state_d  = IDLE;
                end
                WRITE: begin
                    we       = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    state_d  = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rw_q     <= 1'b0;
            rd_ptr_q <= PTR_ZERO;
            wr_ptr_q <= PTR_ZERO;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rw_q     <= rw_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

endmodule

// File: tb/tb_fifo_addr_ctrl.sv
// Directed bench for fifo_addr_ctrl (ADDR_W=3, depth 8, AF_TH=7, AE_TH=1).
module tb_fifo_addr_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rw = 1'b0;
    logic       key = 1'b0;
    logic       flush = 1'b0;
    logic [2:0] out_addr;
    logic       we, re, full, empty, almost_full, almost_empty;
    logic [3:0] count;
    logic       overflow, underflow;

    int tests = 0;
    int failed = 0;

    fifo_addr_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rw           (rw),
        .key          (key),
        .flush        (flush),
        .out_addr     (out_addr),
        .we           (we),
        .re           (re),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One key press; counts strobes over the following cycles and records
    // the address seen with the strobe. flip toggles rw right after the edge.
    task automatic do_op(input logic w, input logic flip,
                         output int n_we, output int n_re, output logic [2:0] addr);
        n_we = 0;
        n_re = 0;
        addr = 3'd0;
        @(negedge clk);
        rw  = w;
        key = 1'b1;
        @(negedge clk);
        key = 1'b0;
        if (flip) rw = ~w;
        repeat (4) begin
            @(negedge clk);
            chk("we_re_exclusive", {31'd0, we & re}, 32'd0);
            if (we) begin n_we++; addr = out_addr; end
            if (re) begin n_re++; addr = out_addr; end
        end
    endtask

    initial begin
        int nw, nr, nh;
        logic [2:0] a;

        // Reset state
        #12;
        chk("rst_empty", {31'd0, empty}, 1);
        chk("rst_count", {28'd0, count}, 0);
        chk("rst_full", {31'd0, full}, 0);
        chk("rst_afull", {31'd0, almost_full}, 0);
        chk("rst_aempty", {31'd0, almost_empty}, 1);
        chk("rst_we_re", {30'd0, we, re}, 0);
        chk("rst_errs", {30'd0, overflow, underflow}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Read from empty
        do_op(1'b0, 1'b0, nw, nr, a);
        chk("uf_no_re", nr, 0);
        chk("uf_flag", {31'd0, underflow}, 1);
        chk("uf_empty", {31'd0, empty}, 1);
        chk("uf_count", {28'd0, count}, 0);

        // Fill 8
        for (int i = 0; i < 8; i++) begin
            do_op(1'b1, 1'b0, nw, nr, a);
            chk("fill_we", nw, 1);
            chk("fill_addr", {29'd0, a}, i);
            if (i == 6) begin
                chk("fill7_afull", {31'd0, almost_full}, 1);
                chk("fill7_full", {31'd0, full}, 0);
            end
        end
        chk("full_count", {28'd0, count}, 8);
        chk("full_flag", {31'd0, full}, 1);
        chk("full_aempty", {31'd0, almost_empty}, 0);
        do_op(1'b1, 1'b0, nw, nr, a);
        chk("ovf_no_we", nw, 0);
        chk("ovf_flag", {31'd0, overflow}, 1);
        chk("ovf_count", {28'd0, count}, 8);

        // Drain 8
        for (int i = 0; i < 8; i++) begin
            do_op(1'b0, 1'b0, nw, nr, a);
            chk("drain_re", nr, 1);
            chk("drain_addr", {29'd0, a}, i);
            if (i == 6) begin
                chk("drain7_count", {28'd0, count}, 1);
                chk("drain7_aempty", {31'd0, almost_empty}, 1);
                chk("drain7_empty", {31'd0, empty}, 0);
            end
        end
        chk("drained_empty", {31'd0, empty}, 1);

        // Second lap: write 3
        for (int i = 0; i < 3; i++) begin
            do_op(1'b1, 1'b0, nw, nr, a);
            chk("lap2_we", nw, 1);
            chk("lap2_addr", {29'd0, a}, i);
        end
        chk("lap2_count", {28'd0, count}, 3);
        chk("lap2_empty", {31'd0, empty}, 0);
        chk("lap2_full", {31'd0, full}, 0);

        // Reach count 5, then flush during WRITE_CHECK
        do_op(1'b1, 1'b0, nw, nr, a);
        do_op(1'b1, 1'b0, nw, nr, a);
        chk("pre_flush_count", {28'd0, count}, 5);
        nh = 0;
        @(negedge clk);
        rw  = 1'b1;
        key = 1'b1;
        @(negedge clk);
        key   = 1'b0;
        flush = 1'b1;
        if (we) nh++;
        @(negedge clk);
        flush = 1'b0;
        repeat (3) begin
            if (we) nh++;
            @(negedge clk);
        end
        chk("flush_no_we", nh, 0);
        chk("flush_count", {28'd0, count}, 0);
        chk("flush_empty", {31'd0, empty}, 1);
        chk("flush_errs", {30'd0, overflow, underflow}, 0);
        do_op(1'b1, 1'b0, nw, nr, a);
        chk("post_flush_we", nw, 1);
        chk("post_flush_addr", {29'd0, a}, 0);

        // rw changed after the edge must not alter the operation
        do_op(1'b1, 1'b1, nw, nr, a);
        chk("rwlatch_we", nw, 1);
        chk("rwlatch_re", nr, 0);
        chk("rwlatch_addr", {29'd0, a}, 1);
        chk("rwlatch_count", {28'd0, count}, 2);

        // Key held high for 20 cycles
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        nh = 0;
        rw  = 1'b1;
        key = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (we) nh++;
        end
        key = 1'b0;
        repeat (3) @(negedge clk);
        chk("hold_one_we", nh, 1);
        chk("hold_count", {28'd0, count}, 1);

        // Reset while in READ
        @(negedge clk);
        rw  = 1'b0;
        key = 1'b1;
        @(negedge clk);
        key = 1'b0;
        @(negedge clk);
        chk("in_read_re", {31'd0, re}, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_re", {31'd0, re}, 0);
        chk("rst_mid_empty", {31'd0, empty}, 1);
        chk("rst_mid_count", {28'd0, count}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(1'b1, 1'b0, nw, nr, a);
        chk("post_rst_addr", {29'd0, a}, 0);
        chk("post_rst_count", {28'd0, count}, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
